// File: rtl/fractal_sync_br_dispatch.sv
// Back-routing response dispatcher.
//
// Queues completed synchronizations as {idx, sd} entries. For each entry it
// raises a response on every port named in the SD mask. Each port then
// finishes its own valid/ready handshake, independently of the others.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   req_valid_i   completion request valid
//   req_ready_o   completion request ready (FIFO not full)
//   req_idx_i     index of the completed register
//   req_sd_i      SD mask of ports to answer
//   resp_valid_o  per-port response valid
//   resp_ready_i  per-port response ready
//   resp_idx_o    index of the response in flight, shared by all ports
//   busy_o        dispatching, or completions still queued
//   err_o         one-cycle pulse after a request with an all-zero SD mask is accepted
module fractal_sync_br_dispatch #(
  parameter int unsigned IDX_WIDTH  = 1,
  parameter int unsigned SD_WIDTH   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IDX_WIDTH-1:0] req_idx_i,
  input  logic [SD_WIDTH-1:0]  req_sd_i,
  output logic [SD_WIDTH-1:0]  resp_valid_o,
  input  logic [SD_WIDTH-1:0]  resp_ready_i,
  output logic [IDX_WIDTH-1:0] resp_idx_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = IDX_WIDTH + SD_WIDTH;

  typedef enum logic [0:0] {StIdle, StDispatch} state_e;

  state_e               state_q, state_d;
  logic [SD_WIDTH-1:0]  pending_q, pending_d;
  logic [IDX_WIDTH-1:0] cur_idx_q, cur_idx_d;
  logic                 err_q;

  logic [EntW-1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic                 fifo_full, fifo_empty;
  logic                 push, pop, zero_acc;
  logic [EntW-1:0]      head;
  logic [SD_WIDTH-1:0]  remaining;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // No bypass: a full FIFO holds ready low even in a cycle that pops.
  assign req_ready_o = !fifo_full;
  assign push        = req_valid_i && !fifo_full && (req_sd_i != '0);
  assign zero_acc    = req_valid_i && !fifo_full && (req_sd_i == '0);

  // Ports not currently valid cannot clear anything, since pending is already 0 there.
  assign remaining = pending_q & ~resp_ready_i;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cur_idx_d = cur_idx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          pending_d = head[SD_WIDTH-1:0];
          cur_idx_d = head[EntW-1:SD_WIDTH];
          state_d   = StDispatch;
        end
      end
      StDispatch: begin
        pending_d = remaining;
        if (remaining == '0) begin
          if (!fifo_empty) begin
            // Load the next entry back-to-back, with no idle cycle.
            pop       = 1'b1;
            pending_d = head[SD_WIDTH-1:0];
            cur_idx_d = head[EntW-1:SD_WIDTH];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      cur_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_idx_q <= cur_idx_d;
      err_q     <= zero_acc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {req_idx_i, req_sd_i};
  end

  assign resp_valid_o = (state_q == StDispatch) ? pending_q : '0;
  assign resp_idx_o   = cur_idx_q;
  assign busy_o       = (state_q == StDispatch) || !fifo_empty;
  assign err_o        = err_q;

endmodule
